sequence_generator: RTL and testbench



---
 rtl/sequence_generator.sv | 110 +++++++++++
 tb/tb_sequence_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial transmitter: latches the switch pattern on a button edge and
// shifts it out LSB first, one bit every DIV clock cycles.
module sequence_generator #(
  parameter int unsigned DIV   = 100000000,
  parameter int unsigned CNT_W = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic [7:0] switch,
  input  logic       repeat_en,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [2:0] bit_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [7:0]       pat_q, pat_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             button_q;
  logic             trig;
  logic             load;

  assign trig = button & ~button_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: load = trig;
      SEND: begin
        if (trig) begin
          load = 1'b1;
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            sh_d  = sh_q >> 1;
            idx_d = idx_q + 3'd1;
          end else if (repeat_en) begin
            sh_d  = pat_q;
            idx_d = 3'd0;
          end else begin
            state_d = DONE;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
    // a trigger restarts from any legal state, including mid-pattern
    if (load) begin
      state_d = SEND;
      pat_d   = switch;
      sh_d    = switch;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      button_q  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      bit_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      button_q  <= button;
      ser_out   <= (state_d == SEND) & sh_d[0];
      ser_valid <= (state_d == SEND) && (cnt_d == '0);
      bit_idx   <= idx_d;
      busy      <= (state_d == SEND);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: DIV=4 and DIV=2 instances share stimulus
// and are compared every cycle against a timing-rule model.
module tb_sequence_generator;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            button = 1'b0;
  logic            repeat_en = 1'b0;
  logic [7:0]      switch = 8'h00;
  logic [1:0]      so, sv, bs, dn;
  logic [1:0][2:0] bi;

  int n_run = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sequence_generator #(.DIV(4), .CNT_W(3)) u4 (
    .clk(clk), .rst_n(rst_n), .button(button), .switch(switch),
    .repeat_en(repeat_en), .ser_out(so[0]), .ser_valid(sv[0]),
    .bit_idx(bi[0]), .busy(bs[0]), .done(dn[0])
  );

  sequence_generator #(.DIV(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .button(button), .switch(switch),
    .repeat_en(repeat_en), .ser_out(so[1]), .ser_valid(sv[1]),
    .bit_idx(bi[1]), .busy(bs[1]), .done(dn[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Model: position n counts cycles since the trigger, bit = n / DIV.
  typedef enum {M_IDLE, M_SEND, M_DONE} mode_e;
  int         div_m [2] = '{4, 2};
  mode_e      mode  [2] = '{M_IDLE, M_IDLE};
  int         n     [2] = '{0, 0};
  logic [7:0] pat   [2] = '{8'h00, 8'h00};
  logic       prev_btn  = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mode[i] = M_IDLE;
        n[i]    = 0;
        pat[i]  = 8'h00;
      end
      prev_btn = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (button && !prev_btn) begin
          mode[i] = M_SEND;
          n[i]    = 0;
          pat[i]  = switch;
        end else if (mode[i] == M_SEND) begin
          if (n[i] + 1 == 8 * div_m[i]) begin
            if (repeat_en) n[i] = 0;
            else mode[i] = M_DONE;
          end else begin
            n[i] = n[i] + 1;
          end
        end
      end
      prev_btn = button;
    end
  end

  function automatic logic [6:0] expect_out(input int i);
    int b;
    b = n[i] / div_m[i];
    case (mode[i])
      M_SEND:  return {pat[i][b], (n[i] % div_m[i]) == 0, 3'(b), 2'b10};
      M_DONE:  return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "model_div4" : "model_div2",
            32'({so[i], sv[i], bi[i], bs[i], dn[i]}),
            32'(expect_out(i)));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [7:0] sw;
    logic       rep;
    string      seq;
    int         passes;
    logic       exp_done;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int  k;
    int  got;
    byte ch;
    vecs[0] = '{8'hD4, 1'b0, "00101011", 1, 1'b1};
    vecs[1] = '{8'h5A, 1'b1, "01011010", 2, 1'b0};
    vecs[2] = '{8'h81, 1'b0, "10000001", 1, 1'b1};

    step();
    step();
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", 32'({so[i], sv[i], bi[i], bs[i], dn[i]}), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Table vectors on the DIV=4 instance, button held throughout
    for (int v = 0; v < 3; v++) begin
      button = 1'b0;
      step();
      switch    = vecs[v].sw;
      repeat_en = vecs[v].rep;
      button    = 1'b1;
      @(posedge clk);
      for (int c = 0; c < vecs[v].passes * 32; c++) begin
        @(negedge clk);
        k  = (c / 4) % 8;
        ch = vecs[v].seq[k];
        chk("vec_bit", 32'(so[0]), 32'(ch == 8'h31));
        chk("vec_valid", 32'(sv[0]), 32'((c % 4) == 0));
        chk("vec_idx", 32'(bi[0]), 32'(k));
      end
      @(negedge clk);
      chk("vec_done", 32'(dn[0]), 32'(vecs[v].exp_done));
      chk("vec_busy", 32'(bs[0]), 32'(!vecs[v].exp_done));
      if (vecs[v].rep) begin
        repeat_en = 1'b0;
        got = -1;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (dn[0]) begin
            got = c;
            break;
          end
        end
        chk("repeat_stop_done", 32'(got >= 0), 32'd1);
      end else begin
        repeat (10) @(negedge clk);
        chk("held_button_done", 32'({bs[0], dn[0]}), 32'b01);
      end
    end

    // Abort mid-pattern with a new trigger
    button = 1'b0;
    step();
    switch = 8'hFF;
    button = 1'b1;
    @(posedge clk);
    got = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bi[0] == 3'd3) begin
        got = c;
        break;
      end
    end
    chk("reach_bit3", 32'(got >= 0), 32'd1);
    step();
    switch = 8'h00;
    button = 1'b0;
    step();
    button = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_restart", 32'({so[0], sv[0], bi[0], bs[0], dn[0]}),
        32'b1_1_000_1_0 & 32'b0_1_000_1_0);
    got = -1;
    for (int c = 2; c < 45; c++) begin
      @(negedge clk);
      if (dn[0]) begin
        got = c;
        break;
      end
    end
    chk("abort_done_cycle", 32'(got), 32'd33);

    // Reset mid-transmission with button still held
    button = 1'b0;
    step();
    switch = 8'hA5;
    button = 1'b1;
    got = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bs[0] && bi[0] == 3'd5) begin
        got = c;
        break;
      end
    end
    chk("reach_bit5", 32'(got >= 0), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk("async_reset", 32'({so[i], sv[i], bi[i], bs[i], dn[i]}), 32'd0);
    step();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held_after_reset", 32'({so[0], sv[0], bi[0], bs[0], dn[0]}),
        32'b1_1_000_1_0);

    // DIV=2: switch churns during SEND, then a retrigger clears done
    button = 1'b0;
    step();
    switch = 8'h3C;
    button = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      switch = 8'($urandom);
      chk("div2_bit", 32'(so[1]), 32'(c >= 4 && c < 12));
    end
    @(negedge clk);
    chk("div2_done", 32'({bs[1], dn[1]}), 32'b01);
    button = 1'b0;
    step();
    button = 1'b1;
    @(posedge clk);
    #1;
    chk("div2_retrig", 32'({bs[1], dn[1]}), 32'b10);

    // Random stimulus against the model
    repeat (1200) begin
      step();
      if ($urandom_range(0, 39) == 0) button = ~button;
      if ($urandom_range(0, 49) == 0) repeat_en = ~repeat_en;
      switch = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
